vcd_down_cnt_le: RTL and testbench
==================================

// Module: vcd_down_cnt_le
// PURPOSE
//  - Cascadable M-bit binary down-counter with clock enable, synchronous parallel load and asynchronous reset.
//  - Counterpart of the team's up-counter (TC at all-ones): counts toward zero, flags TC at zero, emits CEO = borrow-out.
//  - Stages chain as CEO(n) -> ce(n+1) into wide down-counters, timers and programmable period dividers.
// PARAMETERS
//  - M   default 4   counter width in bits; legal range 2..32
// PORTS
//  - clk  in   1  clock; all state updates on posedge clk
//  - R    in   1  reset, asynchronous, active-high
//  - ce   in   1  clock enable / borrow-in from the previous stage
//  - L    in   1  synchronous parallel load strobe
//  - DI   in   M  parallel load data
//  - Q    out  M  counter state (registered)
//  - TC   out  1  terminal count: 1 iff Q == 0
//  - CEO  out  1  borrow-out: ce & TC
// BEHAVIOUR
//  - Reset:
//    - R=1 at any time forces Q = {M{1'b1}} immediately, with no clock edge needed. TC=0, CEO=0.
//    - Reload register P = {M{1'b1}}.
//    - Release is synchronous to the next posedge.
//  - Posedge priority: R > L > ce.
//    - L=1: Q <= DI and P <= DI, regardless of ce. No decrement in that cycle.
//    - L=0, ce=1, Q!=0: Q <= Q - 1, computed modulo 2^M.
//    - L=0, ce=1, Q==0: Q <= wrap value (see CONFIGURATION).
//    - L=0, ce=0: Q holds.
//  - TC and CEO are combinational from Q and ce, with no register stage.
//    - CEO is asserted in the same cycle in which the stage wraps.
//  - Latency:
//    - Load visible on Q one cycle after the L edge.
//    - DI=0 load gives TC=1 in the following cycle.
//  - Reset mid-count: Q jumps to all-ones asynchronously. The pending load or decrement in that cycle is discarded.
//  - Period: with ce held at 1 and no load, TC pulses once every 2^M cycles (non-reload) or every P+1 cycles (reload).
//  - Internal 2-state mode FSM:
//    - States: FREE and ARMED. FREE after reset.
//    - FREE -> ARMED on L=1.
//    - ARMED -> FREE only on R.
//    - Without the reload feature, the FSM and P are not instantiated.
//  - Cascade: for N chained stages with stage0 ce=1, the aggregate sequence is a monotonic N*M-bit down-count.
//  - L shared across stages loads all stages in the same cycle.
// CONFIGURATION
//  - Macro VCD_RELOAD_EN.
//  - Defined:
//    - State P and the FREE/ARMED FSM are instantiated.
//    - On wrap (ce=1, Q==0, L=0): Q <= {M{1'b1}} in FREE, Q <= P in ARMED.
//    - Result: a programmable divide-by-(DI+1) divider.
//    - P=0 in ARMED holds Q at 0, with TC=1 and CEO=ce continuously.
//  - Undefined:
//    - Wrap always gives Q <= {M{1'b1}}. P and the FSM are absent. L loads Q only.
//  - In both builds, behaviour from reset until the first load is identical.
// TESTING (M=4 unless noted)
//  1. Reset:
//     - Stimulus: R=1 asserted between clock edges.
//     - Expect: Q=4'hF, TC=0 and CEO=0 before the next posedge.
//     - Then R=0, ce=1 for 16 cycles: Q = F,E,...,0,F. TC=1 exactly at Q=0.
//  2. Load and priority:
//     - Stimulus: at Q=9, assert L=1, DI=3 with ce=1.
//     - Expect: Q=3 next cycle (no decrement).
//     - Then R=1 together with L=1: Q=F (reset wins).
//  3. Enable gating:
//     - Stimulus: ce=0 for 5 cycles at Q=2.
//     - Expect: Q stays 2.
//     - Then ce=1 for 2 cycles: Q=0, TC=1.
//     - Toggling ce at Q=0: CEO follows ce combinationally.
//  4. Reload (VCD_RELOAD_EN defined):
//     - Stimulus: L=1, DI=4, then ce=1.
//     - Expect: Q = 4,3,2,1,0,4,3..., a period of 5 cycles, with TC pulse width 1.
//     - DI=0 load: TC=1 constant.
//     - Without the macro, the same stimulus gives 4,3,2,1,0,F,E...
//  5. Cascade:
//     - Stimulus: two stages (CEO0 -> ce1) loaded with 8'h10, ce=1.
//     - Expect: aggregate 10,0F,0E...
//     - CEO1=1 only while the aggregate is 00 and ce=1.
//  6. Reset mid-operation (reload build):
//     - Stimulus: ARMED with P=6, R pulse at Q=3.
//     - Expect: Q=F. The next wrap goes to F, not 6 (FSM back in FREE).

Source files
------------

// File: rtl/vcd_down_cnt_le.sv
// Cascadable M-bit down-counter with clock enable, synchronous load and async reset.
// Define VCD_RELOAD_EN to wrap to the last loaded value (divide-by-(DI+1)) once armed by a load.
module vcd_down_cnt_le #(
   parameter int M = 4
) (
   input  logic         clk,
   input  logic         R,
   input  logic         ce,
   input  logic         L,
   input  logic [M-1:0] DI,
   output logic [M-1:0] Q,
   output logic         TC,
   output logic         CEO
);

   logic [M-1:0] wrapVal;
   logic [M-1:0] qNext;

`ifdef VCD_RELOAD_EN
   typedef enum logic {FREE, ARMED} mode_t;

   mode_t        state;
   mode_t        stateNext;
   logic [M-1:0] p;

   // The first load arms the reload; only reset disarms it.
   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         state <= FREE;
         p     <= '1;
      end else begin
         state <= stateNext;
         if (L)
            p <= DI;
      end
   end

   always_comb begin
      stateNext = state;
      wrapVal   = '1;
      if (L)
         stateNext = ARMED;
      if (state == ARMED)
         wrapVal = p;
   end
`else
   assign wrapVal = '1;
`endif

   always_comb begin
      qNext = Q;
      if (L)
         qNext = DI;
      else if (ce)
         qNext = (Q == '0) ? wrapVal : Q - 1'b1;
   end

   always_ff @(posedge clk or posedge R) begin
      if (R)
         Q <= '1;
      else
         Q <= qNext;
   end

   // Borrow-out is combinational so a chained stage decrements in the same cycle this one wraps.
   assign TC  = (Q == '0);
   assign CEO = ce & TC;

endmodule

// File: tb/tb_vcd_down_cnt_le.sv
// Self-checking bench for vcd_down_cnt_le: directed steps, random traffic and a two-stage cascade.
// Works with or without VCD_RELOAD_EN; the reference model follows the same macro.
module tb_vcd_down_cnt_le;

   logic       clk;
   logic       R, ce, L;
   logic [3:0] DI;
   logic [3:0] Q;
   logic       TC, CEO;

   logic       cR, cce, cL;
   logic [7:0] cDI;
   logic [3:0] q0, q1;
   logic       tc0, tc1, ceo0, ceo1;

   int total = 0;
   int bad   = 0;

   int mq, mp, agg;
   bit marmed;

   vcd_down_cnt_le #(.M(4)) dut (
      .clk(clk), .R(R), .ce(ce), .L(L), .DI(DI), .Q(Q), .TC(TC), .CEO(CEO)
   );

   vcd_down_cnt_le #(.M(4)) c0 (
      .clk(clk), .R(cR), .ce(cce), .L(cL), .DI(cDI[3:0]), .Q(q0), .TC(tc0), .CEO(ceo0)
   );

   vcd_down_cnt_le #(.M(4)) c1 (
      .clk(clk), .R(cR), .ce(ceo0), .L(cL), .DI(cDI[7:4]), .Q(q1), .TC(tc1), .CEO(ceo1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: value counts down, wrapping to 15 or (once armed) to the last loaded value.
   task automatic modelReset();
      mq     = 15;
      mp     = 15;
      marmed = 0;
   endtask

   task automatic modelStep(input bit l, input bit c, input int di);
      if (l) begin
         mq = di;
`ifdef VCD_RELOAD_EN
         mp     = di;
         marmed = 1;
`endif
      end else if (c) begin
         if (mq == 0)
            mq = marmed ? mp : 15;
         else
            mq = mq - 1;
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [3:0] expQ;
      logic       expTc, expCeo;
      expQ   = mq[3:0];
      expTc  = (mq == 0);
      expCeo = ce && (mq == 0);
      total++;
      assert (Q === expQ) else begin
         bad++;
         $error("[TB] FAIL %s Q got %h want %h", tag, Q, expQ);
      end
      total++;
      assert (TC === expTc) else begin
         bad++;
         $error("[TB] FAIL %s TC got %b want %b", tag, TC, expTc);
      end
      total++;
      assert (CEO === expCeo) else begin
         bad++;
         $error("[TB] FAIL %s CEO got %b want %b", tag, CEO, expCeo);
      end
   endtask

   // Drive between edges, check the combinational/async view, then check after the edge.
   task automatic applyStimulus(input bit r, input bit l, input bit c, input logic [3:0] di,
                                input string tag);
      R  = r;
      L  = l;
      ce = c;
      DI = di;
      #1;
      if (r)
         modelReset();
      checkOutput({tag, "_pre"});
      @(posedge clk);
      if (!r)
         modelStep(l, c, int'(di));
      #1;
      checkOutput(tag);
      @(negedge clk);
   endtask

   task automatic checkCascade(input string tag);
      logic       expCeo1;
      expCeo1 = cce && (agg == 0);
      total++;
      assert ({q1, q0} === agg[7:0]) else begin
         bad++;
         $error("[TB] FAIL %s agg got %h want %h", tag, {q1, q0}, agg[7:0]);
      end
      total++;
      assert (ceo1 === expCeo1) else begin
         bad++;
         $error("[TB] FAIL %s CEO1 got %b want %b", tag, ceo1, expCeo1);
      end
   endtask

   task automatic cascadeStep(input bit l, input bit c, input logic [7:0] di, input string tag);
      cL  = l;
      cce = c;
      cDI = di;
      #1;
      checkCascade({tag, "_pre"});
      @(posedge clk);
      if (l)
         agg = int'(di);
      else if (c)
         agg = (agg + 255) % 256;
      #1;
      checkCascade(tag);
      @(negedge clk);
   endtask

   initial begin
      int guard;
      R = 1'b0; ce = 1'b0; L = 1'b0; DI = 4'h0;
      cR = 1'b1; cce = 1'b0; cL = 1'b0; cDI = 8'h00;
      modelReset();
      @(negedge clk);

      // Reset asserted between edges, then a full count cycle.
      applyStimulus(1, 0, 1, 4'h0, "reset");
      for (int i = 0; i < 17; i++)
         applyStimulus(0, 0, 1, 4'h0, "count");

      // Load beats decrement; reset beats load.
      guard = 0;
      while (mq != 9 && guard < 20) begin
         applyStimulus(0, 0, 1, 4'h0, "toNine");
         guard++;
      end
      total++;
      assert (guard < 20) else begin
         bad++;
         $error("[TB] FAIL reachNine guard got %0d want <20", guard);
      end
      applyStimulus(0, 1, 1, 4'h3, "loadPri");
      applyStimulus(1, 1, 1, 4'h5, "resetPri");

      // Enable gating and combinational borrow-out.
      applyStimulus(0, 1, 0, 4'h2, "loadTwo");
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 0, 4'h0, "hold");
      for (int i = 0; i < 2; i++)
         applyStimulus(0, 0, 1, 4'h0, "toZero");
      ce = 1'b0; #1; checkOutput("ceoLow");
      ce = 1'b1; #1; checkOutput("ceoHigh");
      ce = 1'b0; #1; checkOutput("ceoLow2");
      @(negedge clk);

      // Divider behaviour after load, including a zero load.
      applyStimulus(0, 1, 0, 4'h4, "loadFour");
      for (int i = 0; i < 12; i++)
         applyStimulus(0, 0, 1, 4'h0, "period");
      applyStimulus(0, 1, 1, 4'h0, "loadZero");
      for (int i = 0; i < 5; i++)
         applyStimulus(0, 0, 1, 4'h0, "zeroRun");

      // Reset mid-operation drops the armed reload.
      applyStimulus(0, 1, 0, 4'h6, "loadSix");
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 1, 4'h0, "toThree");
      applyStimulus(1, 0, 1, 4'h0, "midReset");
      for (int i = 0; i < 18; i++)
         applyStimulus(0, 0, 1, 4'h0, "afterReset");

      // Random traffic.
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
                       ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), "rand");

      // Cascade from reset, with random borrow-in gating.
      cR = 1'b1; #1;
      agg = 255;
      checkCascade("cascReset");
      @(negedge clk);
      cR = 1'b0;
      for (int i = 0; i < 300; i++)
         cascadeStep(0, ($urandom_range(0, 3) != 0), 8'h00, "casc");
`ifndef VCD_RELOAD_EN
      cascadeStep(1, 1, 8'h10, "cascLoad");
      for (int i = 0; i < 20; i++)
         cascadeStep(0, 1, 8'h00, "cascRun");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
